// File: rtl/mem_write_display_ctrl_pkg.sv
// mwd_pkg: shared types and constants for the store monitor and its BCD converters
package mwd_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
    typedef logic [3:0] bcd_digit_t;
    localparam int SHIFT_ITERS = 32;
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/mem_write_display_ctrl_if.sv
// mem_write_display_ctrl_if: processor data-memory store port as seen by the monitor
interface mem_write_display_ctrl_if;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    modport master (output mem_write, data_adr, write_data);
    modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_display_ctrl_bin2bcd.sv
// bin2bcd_seq: 32-bit to 10-digit double-dabble, one shift per cycle, exposes the low NDIG digits
module bin2bcd_seq
    import mwd_pkg::*;
#(
    parameter int NDIG = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       din,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d, adj;
    logic [4:0]  cnt_q, cnt_d;
    logic        act_q, act_d;
    // add-3 correction then shift; done marks the cycle whose edge performs the last shift
    always_comb begin
        adj   = '0;
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        act_d = act_q;
        for (int i = 0; i < 10; i++) adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        done = act_q && cnt_q == 5'(SHIFT_ITERS - 1);
        if (start) begin
            bin_d = din;
            bcd_d = '0;
            cnt_d = '0;
            act_d = 1'b1;
        end else if (act_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 5'd1;
            act_d = !done;
        end
    end
    // converter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end
    assign bcd = bcd_q[4*NDIG-1:0];
endmodule

// File: rtl/mem_write_display_ctrl.sv
// mem_write_display_ctrl: captures stores, converts address/data to BCD digits, tracks success and counts
module mem_write_display_ctrl
    import mwd_pkg::*;
#(
    parameter logic [31:0] EXP_ADR  = 32'd100,
    parameter logic [31:0] EXP_DATA = 32'd7,
    parameter int          CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_write_display_ctrl_if.slave st,
    output logic [11:0]             adr_bcd,
    output logic [3:0]              data_bcd,
    output logic                    digits_valid,
    output logic                    busy,
    output logic                    success,
    output logic [CNT_W-1:0]        write_count,
    output logic [CNT_W-1:0]        drop_count
);
    state_t           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_adr_q, pend_adr_d, pend_data_q, pend_data_d;
    logic [11:0]      adr_bcd_q, adr_bcd_d;
    bcd_digit_t       data_bcd_q, data_bcd_d;
    logic             digits_valid_q, digits_valid_d, success_q, success_d;
    logic [CNT_W-1:0] write_count_q, write_count_d, drop_count_q, drop_count_d;
    logic             start, adr_done, data_done;
    logic [31:0]      conv_adr, conv_data;
    logic [11:0]      adr_dig;
    bcd_digit_t       data_dig;
    // FSM, pending buffer, counters; a pending entry always wins the converter over a fresh store
    always_comb begin
        state_d        = state_q;
        pend_valid_d   = pend_valid_q;
        pend_adr_d     = pend_adr_q;
        pend_data_d    = pend_data_q;
        adr_bcd_d      = adr_bcd_q;
        data_bcd_d     = data_bcd_q;
        digits_valid_d = digits_valid_q;
        success_d      = success_q;
        write_count_d  = write_count_q;
        drop_count_d   = drop_count_q;
        start          = 1'b0;
        conv_adr       = pend_valid_q ? pend_adr_q : st.data_adr;
        conv_data      = pend_valid_q ? pend_data_q : st.write_data;
        case (state_q)
            IDLE: begin
                start   = pend_valid_q || st.mem_write;
                state_d = start ? CONVERT : IDLE;
            end
            CONVERT: state_d = (adr_done && data_done) ? LOAD : CONVERT;
            LOAD: begin
                adr_bcd_d      = adr_dig;
                data_bcd_d     = data_dig;
                digits_valid_d = 1'b1;
                start          = pend_valid_q;
                state_d        = pend_valid_q ? CONVERT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start && pend_valid_q) pend_valid_d = 1'b0;
        if (st.mem_write) begin
            if (st.data_adr == EXP_ADR && st.write_data == EXP_DATA) success_d = 1'b1;
            if (~&write_count_q) write_count_d = write_count_q + CNT_W'(1);
            if (!(state_q == IDLE && !pend_valid_q)) begin
                if (state_q == CONVERT && pend_valid_q && ~&drop_count_q) drop_count_d = drop_count_q + CNT_W'(1);
                pend_valid_d = 1'b1;
                pend_adr_d   = st.data_adr;
                pend_data_d  = st.write_data;
            end
        end
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            pend_valid_q   <= 1'b0;
            pend_adr_q     <= '0;
            pend_data_q    <= '0;
            adr_bcd_q      <= '0;
            data_bcd_q     <= '0;
            digits_valid_q <= 1'b0;
            success_q      <= 1'b0;
            write_count_q  <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            pend_valid_q   <= pend_valid_d;
            pend_adr_q     <= pend_adr_d;
            pend_data_q    <= pend_data_d;
            adr_bcd_q      <= adr_bcd_d;
            data_bcd_q     <= data_bcd_d;
            digits_valid_q <= digits_valid_d;
            success_q      <= success_d;
            write_count_q  <= write_count_d;
            drop_count_q   <= drop_count_d;
        end
    end
    bin2bcd_seq #(.NDIG(3)) u_adr (
        .clk(clk), .reset(reset), .start(start), .din(conv_adr), .done(adr_done), .bcd(adr_dig)
    );
    bin2bcd_seq #(.NDIG(1)) u_data (
        .clk(clk), .reset(reset), .start(start), .din(conv_data), .done(data_done), .bcd(data_dig)
    );
    assign adr_bcd      = adr_bcd_q;
    assign data_bcd     = data_bcd_q;
    assign digits_valid = digits_valid_q;
    assign busy         = state_q != IDLE;
    assign success      = success_q;
    assign write_count  = write_count_q;
    assign drop_count   = drop_count_q;
endmodule

// File: tb/tb_mem_write_display_ctrl.sv
// tb_mem_write_display_ctrl: directed stores with a queued scoreboard of expected display updates
module tb_mem_write_display_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] adr_bcd;
    logic [3:0]  data_bcd;
    logic        digits_valid, busy, success;
    logic [7:0]  write_count, drop_count;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [16:0] v;
        int          due;
    } exp_t;
    exp_t q[$];

    mem_write_display_ctrl_if bus();

    mem_write_display_ctrl dut (
        .clk(clk), .reset(reset), .st(bus.slave),
        .adr_bcd(adr_bcd), .data_bcd(data_bcd), .digits_valid(digits_valid),
        .busy(busy), .success(success), .write_count(write_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // called at a negedge; the following posedge captures the store, returns at the next negedge
    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit push,
                         input logic [16:0] ev, input int lat);
        bus.mem_write  = 1'b1;
        bus.data_adr   = a;
        bus.write_data = d;
        @(negedge clk);
        bus.mem_write = 1'b0;
        if (push) q.push_back('{v: ev, due: cyc + lat});
    endtask

    function automatic logic [34:0] all_outs();
        return {adr_bcd, data_bcd, digits_valid, busy, success, write_count, drop_count};
    endfunction

    // monitor: outputs must hold the previous value one cycle before due and show the new one at due
    initial begin
        logic [16:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset) prev = '0;
            else if (q.size() > 0) begin
                if (cyc == q[0].due - 1) chk("digits_early", {digits_valid, adr_bcd, data_bcd}, prev);
                if (cyc == q[0].due) begin
                    chk("digits", {digits_valid, adr_bcd, data_bcd}, q[0].v);
                    prev = q[0].v;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int t;
        bus.mem_write  = 1'b0;
        bus.data_adr   = '0;
        bus.write_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        reset = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("idle_zero", all_outs(), 0);
        end
        // expected-result store
        store(32'd100, 32'd7, 1, {1'b1, 12'h100, 4'h7}, 33);
        chk("success_capture", success, 1);
        chk("wcount_1", write_count, 1);
        chk("busy_convert", busy, 1);
        chk("valid_before", digits_valid, 0);
        repeat (40) @(negedge clk);
        chk("busy_done", busy, 0);
        // mod 1000 / mod 10 behaviour
        store(32'd12345, 32'hFFFF_FFFF, 1, {1'b1, 12'h345, 4'h5}, 33);
        chk("wcount_2", write_count, 2);
        chk("success_sticky", success, 1);
        repeat (40) @(negedge clk);
        // three back-to-back stores: second is overwritten by the third
        store(32'd4, 32'd9, 1, {1'b1, 12'h004, 4'h9}, 33);
        store(32'd8, 32'd10, 0, '0, 0);
        chk("drop_none", drop_count, 0);
        store(32'd12, 32'd23, 1, {1'b1, 12'h012, 4'h3}, 64);
        chk("drop_1", drop_count, 1);
        chk("wcount_5", write_count, 5);
        repeat (70) @(negedge clk);
        // one store per 34 cycles sustains without drops
        store(32'd999, 32'd123, 1, {1'b1, 12'h999, 4'h3}, 33);
        repeat (33) @(negedge clk);
        store(32'd1000, 32'd40, 1, {1'b1, 12'h000, 4'h0}, 33);
        chk("drop_still_1", drop_count, 1);
        chk("wcount_7", write_count, 7);
        repeat (40) @(negedge clk);
        chk("queue_mid", q.size(), 0);
        // asynchronous reset mid-conversion with a pending entry
        store(32'd500, 32'd1, 0, '0, 0);
        store(32'd600, 32'd2, 0, '0, 0);
        repeat (18) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_async", all_outs(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (80) begin
            @(negedge clk);
            chk("post_reset", all_outs(), 0);
        end
        // saturation of write and drop counters
        for (int i = 0; i < 300; i++) begin
            store(32'(i), 32'(i + 1000), 0, '0, 0);
            if (i == 254) chk("wcount_255", write_count, 255);
        end
        chk("wcount_sat", write_count, 255);
        chk("drop_sat", drop_count, 255);
        chk("success_clear", success, 0);
        repeat (100) @(negedge clk);
        chk("busy_final", busy, 0);
        t = 0;
        while (q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
